context_scheduler: RTL and testbench
====================================

# context_scheduler

Per-cycle hardware-context issue scheduler for the multi-context core. Each cycle it picks one runnable context with rotating round-robin priority and presents it to the fetch stage as a registered one-hot grant plus its binary ID. It also tracks per-context sleep state: timed sleeps for fixed-latency hazards, and untimed sleeps that end on an external wake such as a memory response. Sits between the pipeline control (block, wake, stall) and fetch-stage context muxing.

## Interface
- `LEN_CONTEXT_ID`, default `` `LEN_CONTEXT_ID ``: context ID width; N = 2**LEN_CONTEXT_ID contexts.
- `LEN_WAIT`, default 4: width of the per-context sleep counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ctx_enable`  in  N  contexts allowed to run (start/halt mask).
- `stall`  in  1  pipeline cannot accept a new issue this cycle.
- `block_valid`  in  1  put context `block_id` to sleep.
- `block_id`  in  LEN_CONTEXT_ID  context to block.
- `block_cycles`  in  LEN_WAIT  sleep length in cycles; 0 means sleep until woken.
- `wake_valid`  in  1  wake context `wake_id`.
- `wake_id`  in  LEN_CONTEXT_ID  context to wake.
- `issue_valid`  out  1  registered; a context is granted.
- `issue_onehot`  out  N  registered one-hot grant; all zero when `issue_valid`=0.
- `issue_id`  out  LEN_CONTEXT_ID  registered binary form of `issue_onehot`; 0 when idle.
- `sleeping`  out  N  registered per-context sleep flags.

## Operation
- Per-context state is `sleeping[i]` and `cnt[i]` (LEN_WAIT bits).
- **Block.** In cycle t with `block_valid`, context b=`block_id` is updated at t+1:
  - If `block_cycles`=k>0: `sleeping[b]`=1 and `cnt[b]`=k.
  - If `block_cycles`=0: `sleeping[b]`=1 and `cnt[b]`=0 (untimed).
- **Timed countdown.** While `sleeping[i]`=1 and `cnt[i]`>0, the counter decrements every cycle, independent of `stall`. On the edge where it goes 1→0, `sleeping[i]` clears. Result: `sleeping[b]` is high for cycles t+1..t+k exactly.
- **Wake.** `wake_valid` with `wake_id`=w clears `sleeping[w]` and `cnt[w]` at the next edge. A wake to a non-sleeping context has no effect.
- **Re-block** of an already sleeping context reloads its state with the new `block_cycles`.
- **Block and wake to the same ID in one cycle:** block wins.
- **Eligibility** in cycle t: `elig = ctx_enable & ~sleeping & ~blk_mask`. `blk_mask` is the one-hot of `block_id` when `block_valid`, else 0. A context blocked in cycle t is therefore excluded from the grant computed in t.
- **Round-robin arbitration.**
  - Register `last_grant` (one-hot, N bits).
  - Search order starts at the context after `last_grant` and wraps modulo N.
  - The first eligible context wins.
- **Update when `stall`=0:**
  - If `elig`≠0: issue registers load the winner, `issue_valid`=1, and `last_grant` takes the winner.
  - If `elig`=0: `issue_valid`=0, `issue_onehot`=0, `issue_id`=0, and `last_grant` holds.
- **Update when `stall`=1:** `issue_*` and `last_grant` hold their values. Sleep, block, and wake processing continue. The held grant is not revalidated; discarding it is the pipeline's responsibility.
- **Fairness.** A context eligible on every non-stall cycle is granted within N non-stall cycles.
- **Disable.** Deasserting `ctx_enable[i]` excludes context i from subsequent grants. Its sleep state is retained.

## Timing
- Reset values: `issue_valid`=0, `issue_onehot`=0, `issue_id`=0, `sleeping`=0, all `cnt`=0, `last_grant`=one-hot bit N-1, so context 0 has first priority.
- Latency: inputs in cycle t are reflected on `issue_*` and `sleeping` at t+1. There is no combinational input-to-output path.
- Reset asserted mid-sleep or mid-stall: all state returns to reset values at the next edge, with no residual sleeps.
- `block_id` and `wake_id` are ignored when their valid bit is 0.
- `block_cycles` at maximum (2**LEN_WAIT-1) must sleep the full count without wrap.

## Test plan
Assume N=4 and LEN_WAIT=4 throughout.
- **Full rotation.** Reset, then `ctx_enable`=4'b1111 from cycle 1 → `issue_id`=0,1,2,3,0,1 on cycles 2..7, `issue_valid`=1 throughout.
- **Sparse mask.** `ctx_enable`=4'b0101 → `issue_id` alternates 0,2,0,2. Switching to 4'b1000 → `issue_id`=3 on every subsequent cycle.
- **Timed sleep.** All enabled; block id 1 with `block_cycles`=3 at cycle t → `sleeping[1]` high for cycles t+1..t+3. Context 1 never appears on `issue_*` at t+1..t+4 and reappears within 4 cycles afterwards.
- **Untimed sleep.** Block id 2 with `block_cycles`=0 at t, then wake id 2 at t+6 → `sleeping[2]` high t+1..t+6 and low at t+7. Same-cycle block and wake of id 2 → `sleeping[2]`=1 next cycle.
- **Stall.** Rotation running with `issue_id`=1 when `stall` is held 3 cycles → `issue_id` stays 1 and `issue_valid` stays 1. The first non-stall grant is 2. A timed sleep started during the stall still expires on schedule.
- **Idle and reset.** All contexts sleeping → `issue_valid`=0, `issue_onehot`=0. Asserting `rst` mid-sleep → next cycle `sleeping`=0, and after reset the first grant is context 0.

Source files
------------

// File: rtl/context_scheduler.sv
// context_scheduler
//
// Per-cycle issue scheduler for a multi-context core. Every cycle it picks
// one runnable context with rotating round-robin priority. The choice goes
// to the fetch stage as a registered one-hot grant plus its binary ID. It
// also tracks per-context sleeps. A timed sleep counts down by itself. An
// untimed sleep lasts until an external wake.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   ctx_enable    N-bit mask of contexts allowed to run
//   stall         pipeline cannot take a new issue; grant registers hold
//   block_valid   put context block_id to sleep
//   block_id      context to block
//   block_cycles  sleep length in cycles; 0 means sleep until woken
//   wake_valid    wake context wake_id
//   wake_id       context to wake
//   issue_valid   registered: a context is granted
//   issue_onehot  registered one-hot grant, zero when idle
//   issue_id      registered binary grant, zero when idle
//   sleeping      registered per-context sleep flags

`ifndef LEN_CONTEXT_ID
`define LEN_CONTEXT_ID 2
`endif

module context_scheduler #(
  parameter int LEN_CONTEXT_ID = `LEN_CONTEXT_ID,
  parameter int LEN_WAIT       = 4,
  localparam int N             = 1 << LEN_CONTEXT_ID
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              ctx_enable,
  input  logic                      stall,
  input  logic                      block_valid,
  input  logic [LEN_CONTEXT_ID-1:0] block_id,
  input  logic [LEN_WAIT-1:0]       block_cycles,
  input  logic                      wake_valid,
  input  logic [LEN_CONTEXT_ID-1:0] wake_id,
  output logic                      issue_valid,
  output logic [N-1:0]              issue_onehot,
  output logic [LEN_CONTEXT_ID-1:0] issue_id,
  output logic [N-1:0]              sleeping
);

  logic [N-1:0]              last_grant;
  logic [LEN_WAIT-1:0]       cnt [N];

  logic [N-1:0]              blk_mask;
  logic [N-1:0]              elig;
  logic [LEN_CONTEXT_ID-1:0] last_idx;
  logic [LEN_CONTEXT_ID-1:0] probe_idx;
  logic [LEN_CONTEXT_ID-1:0] win_idx;
  logic [N-1:0]              win_onehot;
  logic                      found;

  // Eligibility and round-robin winner selection. A context being blocked
  // this cycle is masked out right away. That way it is never granted in
  // the same cycle it goes to sleep. The search starts one past the last
  // grant and wraps naturally through the LEN_CONTEXT_ID-bit index
  // arithmetic. The last probe lands back on the previous winner itself.
  always_comb begin
    blk_mask = '0;
    if (block_valid) blk_mask[block_id] = 1'b1;
    elig = ctx_enable & ~sleeping & ~blk_mask;

    last_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (last_grant[i]) last_idx = last_idx | i[LEN_CONTEXT_ID-1:0];
    end

    found     = 1'b0;
    win_idx   = '0;
    probe_idx = '0;
    for (int k = 1; k <= N; k++) begin
      probe_idx = last_idx + k[LEN_CONTEXT_ID-1:0];
      if (!found && elig[probe_idx]) begin
        found   = 1'b1;
        win_idx = probe_idx;
      end
    end

    win_onehot = '0;
    win_onehot[win_idx] = found;
  end

  // Grant registers. A stall freezes both the presented grant and the
  // rotation pointer. When nothing is eligible the outputs go idle, but the
  // pointer keeps its position so the rotation resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_onehot <= '0;
      issue_id     <= '0;
      last_grant   <= {1'b1, {(N-1){1'b0}}};
    end else if (!stall) begin
      if (found) begin
        issue_valid  <= 1'b1;
        issue_onehot <= win_onehot;
        issue_id     <= win_idx;
        last_grant   <= win_onehot;
      end else begin
        issue_valid  <= 1'b0;
        issue_onehot <= '0;
        issue_id     <= '0;
      end
    end
  end

  // Per-context sleep state. It runs regardless of stall. A block beats a
  // wake to the same context. A block with zero cycles leaves cnt at 0, so
  // the countdown branch never fires and only a wake ends that sleep. A
  // timed sleep clears on the edge where the counter goes 1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sleeping <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (block_valid && block_id == i[LEN_CONTEXT_ID-1:0]) begin
          sleeping[i] <= 1'b1;
          cnt[i]      <= block_cycles;
        end else if (wake_valid && wake_id == i[LEN_CONTEXT_ID-1:0]) begin
          sleeping[i] <= 1'b0;
          cnt[i]      <= '0;
        end else if (sleeping[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LEN_WAIT'(1);
          if (cnt[i] == LEN_WAIT'(1)) sleeping[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_context_scheduler.sv
// tb_context_scheduler
//
// Directed testbench for context_scheduler with N=4 contexts and
// LEN_WAIT=4. Each scenario task drives its inputs and compares outputs
// against hand-computed values. Inputs are driven and outputs sampled 1ns
// after each rising edge.

module tb_context_scheduler;

  localparam int LCID = 2;
  localparam int LW   = 4;
  localparam int N    = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    ctx_enable;
  logic            stall;
  logic            block_valid;
  logic [LCID-1:0] block_id;
  logic [LW-1:0]   block_cycles;
  logic            wake_valid;
  logic [LCID-1:0] wake_id;
  logic            issue_valid;
  logic [N-1:0]    issue_onehot;
  logic [LCID-1:0] issue_id;
  logic [N-1:0]    sleeping;

  int checks;
  int failures;

  context_scheduler #(.LEN_CONTEXT_ID(LCID), .LEN_WAIT(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctx_enable   (ctx_enable),
    .stall        (stall),
    .block_valid  (block_valid),
    .block_id     (block_id),
    .block_cycles (block_cycles),
    .wake_valid   (wake_valid),
    .wake_id      (wake_id),
    .issue_valid  (issue_valid),
    .issue_onehot (issue_onehot),
    .issue_id     (issue_id),
    .sleeping     (sleeping)
  );

  // Free-running clock, 10ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clear every request input.
  task automatic idle_inputs();
    stall        = 1'b0;
    block_valid  = 1'b0;
    block_id     = '0;
    block_cycles = '0;
    wake_valid   = 1'b0;
    wake_id      = '0;
  endtask

  // Apply reset for one edge and leave all contexts enabled.
  task automatic do_reset();
    idle_inputs();
    ctx_enable = 4'b1111;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reset values, with a live enable mask and request inputs present while
  // rst is high.
  task automatic test_reset();
    idle_inputs();
    ctx_enable   = 4'b1111;
    block_valid  = 1'b1;
    block_id     = 2'd1;
    block_cycles = 4'd5;
    rst = 1'b1;
    step();
    checks++;
    if (issue_valid !== 1'b0 || issue_onehot !== 4'b0000 || issue_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_issue: valid=%0b onehot=%b id=%0d required 0/0000/0",
               issue_valid, issue_onehot, issue_id);
    end
    checks++;
    if (sleeping !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_sleeping: got %b required 0000", sleeping);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  // Full rotation, then a sparse mask, then a single enabled context.
  task automatic test_rotation();
    int exp_rot [6] = '{0, 1, 2, 3, 0, 1};
    int exp_sp  [4] = '{2, 0, 2, 0};
    logic [N-1:0] oh;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      oh = 4'b0001 << exp_rot[c];
      checks++;
      if (issue_valid !== 1'b1 || issue_id !== LCID'(exp_rot[c]) || issue_onehot !== oh) begin
        failures++;
        $display("[TB] FAIL rotation[%0d]: valid=%0b id=%0d onehot=%b required 1/%0d/%b",
                 c, issue_valid, issue_id, issue_onehot, exp_rot[c], oh);
      end
    end
    ctx_enable = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_id !== LCID'(exp_sp[c])) begin
        failures++;
        $display("[TB] FAIL sparse[%0d]: valid=%0b id=%0d required 1/%0d",
                 c, issue_valid, issue_id, exp_sp[c]);
      end
    end
    ctx_enable = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_id !== 2'd3 || issue_onehot !== 4'b1000) begin
        failures++;
        $display("[TB] FAIL only3[%0d]: valid=%0b id=%0d onehot=%b required 1/3/1000",
                 c, issue_valid, issue_id, issue_onehot);
      end
    end
  endtask

  // Block context 1 for 3 cycles. It is skipped from the blocking cycle
  // onward and comes back once its sleep expires.
  task automatic test_timed_sleep();
    int   exp_id  [7] = '{2, 3, 0, 2, 3, 0, 1};
    logic exp_slp [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    step();  // grant 0
    block_valid  = 1'b1;
    block_id     = 2'd1;
    block_cycles = 4'd3;
    for (int c = 0; c < 7; c++) begin
      step();
      block_valid = 1'b0;
      checks++;
      if (issue_id !== LCID'(exp_id[c]) || sleeping[1] !== exp_slp[c]) begin
        failures++;
        $display("[TB] FAIL timed_sleep[%0d]: id=%0d sleeping1=%0b required %0d/%0b",
                 c, issue_id, sleeping[1], exp_id[c], exp_slp[c]);
      end
    end
  endtask

  // Untimed sleep of context 2 ended by a wake. Then a block and a wake of
  // the same context arrive in one cycle, and the block wins.
  task automatic test_untimed_sleep();
    int exp_id [6] = '{1, 3, 0, 1, 3, 0};
    do_reset();
    step();  // grant 0
    block_valid  = 1'b1;
    block_id     = 2'd2;
    block_cycles = 4'd0;
    for (int c = 0; c < 6; c++) begin
      step();
      block_valid = 1'b0;
      checks++;
      if (sleeping[2] !== 1'b1 || issue_id !== LCID'(exp_id[c])) begin
        failures++;
        $display("[TB] FAIL untimed_hold[%0d]: sleeping2=%0b id=%0d required 1/%0d",
                 c, sleeping[2], issue_id, exp_id[c]);
      end
    end
    wake_valid = 1'b1;
    wake_id    = 2'd2;
    step();
    wake_valid = 1'b0;
    checks++;
    if (sleeping[2] !== 1'b0 || issue_id !== 2'd1) begin
      failures++;
      $display("[TB] FAIL untimed_wake: sleeping2=%0b id=%0d required 0/1", sleeping[2], issue_id);
    end
    step();
    checks++;
    if (issue_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL untimed_regrant: id=%0d required 2", issue_id);
    end
    block_valid  = 1'b1;
    block_id     = 2'd2;
    block_cycles = 4'd0;
    wake_valid   = 1'b1;
    wake_id      = 2'd2;
    step();
    idle_inputs();
    checks++;
    if (sleeping[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL block_beats_wake: sleeping2=%0b required 1", sleeping[2]);
    end
    // A wake with valid low must not touch the sleep.
    wake_id = 2'd2;
    step();
    checks++;
    if (sleeping[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wake_ignored: sleeping2=%0b required 1", sleeping[2]);
    end
  endtask

  // Stall holds the grant. A timed sleep begun during the stall still
  // expires on schedule.
  task automatic test_stall();
    logic exp_slp [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    step();  // grant 0
    step();  // grant 1
    stall        = 1'b1;
    block_valid  = 1'b1;
    block_id     = 2'd3;
    block_cycles = 4'd2;
    for (int c = 0; c < 3; c++) begin
      step();
      block_valid = 1'b0;
      checks++;
      if (issue_valid !== 1'b1 || issue_id !== 2'd1 || sleeping[3] !== exp_slp[c]) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%0b id=%0d sleeping3=%0b required 1/1/%0b",
                 c, issue_valid, issue_id, sleeping[3], exp_slp[c]);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL stall_release: valid=%0b id=%0d required 1/2", issue_valid, issue_id);
    end
    step();
    checks++;
    if (issue_id !== 2'd3) begin
      failures++;
      $display("[TB] FAIL stall_after: id=%0d required 3", issue_id);
    end
  endtask

  // The maximum block count sleeps exactly 15 cycles without wrapping.
  // A block_id with block_valid low must be ignored.
  task automatic test_max_sleep();
    do_reset();
    block_id     = 2'd1;
    block_cycles = 4'd7;
    step();
    checks++;
    if (sleeping !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL block_ignored: sleeping=%b required 0000", sleeping);
    end
    block_valid  = 1'b1;
    block_id     = 2'd0;
    block_cycles = 4'd15;
    for (int c = 1; c <= 16; c++) begin
      step();
      block_valid = 1'b0;
      checks++;
      if (sleeping[0] !== (c <= 15)) begin
        failures++;
        $display("[TB] FAIL max_sleep[%0d]: sleeping0=%0b required %0b", c, sleeping[0], c <= 15);
      end
    end
  endtask

  // All contexts asleep gives an idle issue. A reset mid-sleep clears
  // everything, and context 0 is granted first afterwards.
  task automatic test_idle_and_reset();
    do_reset();
    block_valid  = 1'b1;
    block_cycles = 4'd0;
    for (int c = 0; c < 4; c++) begin
      block_id = LCID'(c);
      step();
    end
    block_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || issue_onehot !== 4'b0000 || issue_id !== 2'd0 || sleeping !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL idle_all_asleep: valid=%0b onehot=%b id=%0d sleeping=%b required 0/0000/0/1111",
               issue_valid, issue_onehot, issue_id, sleeping);
    end
    step();
    checks++;
    if (issue_valid !== 1'b0 || issue_onehot !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL idle_hold: valid=%0b onehot=%b required 0/0000", issue_valid, issue_onehot);
    end
    rst = 1'b1;
    step();
    checks++;
    if (sleeping !== 4'b0000 || issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_sleep: sleeping=%b valid=%0b required 0000/0", sleeping, issue_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_id !== 2'd0 || issue_onehot !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL post_reset_grant: valid=%0b id=%0d onehot=%b required 1/0/0001",
               issue_valid, issue_id, issue_onehot);
    end
  endtask

  // Run each scenario in turn.
  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    ctx_enable = '0;
    idle_inputs();
    test_reset();
    test_rotation();
    test_timed_sleep();
    test_untimed_sleep();
    test_stall();
    test_max_sleep();
    test_idle_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
